argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of final-layer scores scanned (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of each signed two's-complement score.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to classify the current scores.
REQ-006 SHALL have port scores  input  [DATA_WIDTH-1:0] x NUM_CLASSES unpacked  final-layer node outputs; index i = class i.
REQ-007 SHALL have port busy  output  1  high while a classification is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when a new result is committed.
REQ-009 SHALL have port valid  output  1  high once at least one result has been committed since reset.
REQ-010 SHALL have port digit  output  4  index of the winning class.
REQ-011 SHALL have port max_score  output  DATA_WIDTH  score of the winning class.
REQ-012 SHALL have port seven_seg  output  8  display pattern {dp,g,f,e,d,c,b,a}, active-high.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, COMMIT.
REQ-014 IDLE: on start=1 SHALL snapshot all scores into an internal register, load best_idx=0, best_val=scores[0], idx=1, go to SCAN.
REQ-015 SCAN: each cycle SHALL compare snapshot[idx] against best_val as signed values; strictly greater replaces best_idx/best_val; idx increments.
REQ-016 SCAN SHALL go to COMMIT in the cycle after processing idx=NUM_CLASSES-1 (NUM_CLASSES-1 scan cycles).
REQ-017 COMMIT: SHALL register digit=best_idx, max_score=best_val, seven_seg pattern, assert done for that one cycle, set valid=1, return to IDLE.
REQ-018 Latency: start sampled at edge T SHALL produce done=1 in cycle T+NUM_CLASSES (10 cycles for default); outputs valid in the same cycle.
REQ-019 busy SHALL be high in SCAN and COMMIT, low in IDLE.
REQ-020 start while busy=1 SHALL be ignored (no restart, no queuing).
REQ-021 Ties SHALL resolve to the lowest index.
REQ-022 Changes on scores after the start edge SHALL NOT affect the in-progress result.
REQ-023 digit, max_score, seven_seg SHALL hold their last committed values until the next COMMIT.
REQ-024 seven_seg[6:0] SHALL encode digit 0..9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); digit >9 SHALL give 7'h79 ("E").
REQ-025 seven_seg[7] (dp) SHALL be 1 when the committed max_score is negative (low-confidence flag), else 0.
REQ-026 When valid=0, seven_seg SHALL be 8'h00 (blank).
REQ-027 start in the same cycle as COMMIT SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, valid=0, digit=0, max_score=0, seven_seg=8'h00, clear internal snapshot/index registers.
REQ-029 rst asserted mid-SCAN SHALL abort the scan with no done pulse and no output update; rst has priority over start.

Verification
REQ-030 scores={0..9 -> 5,12,-3,40,7,0,1,2,3,4}, start pulse -> done at T+10, digit=3, max_score=40, seven_seg=8'h4F, valid=1.
REQ-031 scores with 25 at index 2 and index 7, all else 0 -> digit=2, seven_seg=8'h5B (tie to lowest index).
REQ-032 all scores negative, max -1 at index 9 (16'hFFFF) -> digit=9, max_score=16'hFFFF, seven_seg=8'hEF (dp set).
REQ-033 start, then start again at T+3 and scores changed at T+1 -> exactly one done at T+10, result from snapshot at T, second start ignored.
REQ-034 start, rst at T+5 -> no done, busy=0, valid=0, seven_seg=8'h00; fresh start afterward completes normally in 10 cycles.
REQ-035 after reset with no start -> seven_seg=8'h00, valid=0, busy=0 indefinitely.

Source files
------------

// File: rtl/argmax_classifier.sv
// Argmax over NUM_CLASSES signed scores: snapshots the scores on start, scans one per cycle,
// and commits the winning index, its score and a seven-segment pattern.
module argmax_classifier #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] scores [NUM_CLASSES],
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [3:0]            digit,
    output logic [DATA_WIDTH-1:0] max_score,
    output logic [7:0]            seven_seg
);

    localparam int unsigned IW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] snap_q [NUM_CLASSES];
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         best_idx_q;
    logic [DATA_WIDTH-1:0] best_val_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;
    logic [3:0]            digit_q;
    logic [DATA_WIDTH-1:0] max_score_q;
    logic [7:0]            seven_seg_q;

    logic [DATA_WIDTH-1:0] cand_c;
    logic                  take_c;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    // Strict greater-than keeps the earliest index on ties.
    assign cand_c = snap_q[idx_q];
    assign take_c = $signed(cand_c) > $signed(best_val_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            digit_q     <= '0;
            max_score_q <= '0;
            seven_seg_q <= '0;
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q     <= scores;
                        best_idx_q <= '0;
                        best_val_q <= scores[0];
                        idx_q      <= IW'(1);
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (take_c) begin
                        best_idx_q <= idx_q;
                        best_val_q <= cand_c;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                COMMIT: begin
                    digit_q     <= 4'(best_idx_q);
                    max_score_q <= best_val_q;
                    seven_seg_q <= {best_val_q[DATA_WIDTH-1], seg_decode(4'(best_idx_q))};
                    done_q      <= 1'b1;
                    valid_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    idx_q       <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
    assign digit     = digit_q;
    assign max_score = max_score_q;
    assign seven_seg = seven_seg_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: table of score sets with hand-computed results,
// plus sequences for snapshot, busy-start, commit-start, mid-scan reset and idle behaviour.
module tb_argmax_classifier;

    localparam int N  = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] sc [N];
    logic          busy, done, valid;
    logic [3:0]    digit;
    logic [DW-1:0] max_score;
    logic [7:0]    seven_seg;

    int checks = 0;
    int errors = 0;

    argmax_classifier #(.NUM_CLASSES(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .scores(sc),
        .busy(busy), .done(done), .valid(valid), .digit(digit),
        .max_score(max_score), .seven_seg(seven_seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][DW-1:0] s;
        logic [3:0]           d;
        logic [DW-1:0]        m;
        logic [7:0]           seg;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [N-1:0][DW-1:0] pk(input int a0, a1, a2, a3, a4,
                                                 a5, a6, a7, a8, a9);
        logic [N-1:0][DW-1:0] r;
        r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3); r[4] = DW'(a4);
        r[5] = DW'(a5); r[6] = DW'(a6); r[7] = DW'(a7); r[8] = DW'(a8); r[9] = DW'(a9);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N-1:0][DW-1:0] s);
        for (int i = 0; i < N; i++) sc[i] = s[i];
    endtask

    // Pulse start for one edge, then count cycles until done (bounded).
    task automatic run_and_wait(input string name, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd10);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [3:0] hold_d;

        vecs[0] = '{s: pk(5, 12, -3, 40, 7, 0, 1, 2, 3, 4),           d: 4'd3, m: 16'd40,   seg: 8'h4F};
        vecs[1] = '{s: pk(0, 0, 25, 0, 0, 0, 0, 25, 0, 0),            d: 4'd2, m: 16'd25,   seg: 8'h5B};
        vecs[2] = '{s: pk(-10, -20, -5, -100, -7, -3, -2, -50, -9, -1), d: 4'd9, m: 16'hFFFF, seg: 8'hEF};
        vecs[3] = '{s: pk(-32768, 1, -5, -5, -5, -5, -5, -5, -5, -5), d: 4'd1, m: 16'd1,    seg: 8'h06};
        vecs[4] = '{s: pk(7, 7, 7, 7, 7, 7, 7, 7, 7, 7),              d: 4'd0, m: 16'd7,    seg: 8'h3F};
        vecs[5] = '{s: pk(0, 1, 2, 3, 4, 32767, 6, 7, 8, 9),          d: 4'd5, m: 16'h7FFF, seg: 8'h6D};
        vecs[6] = '{s: pk(-4, -4, -4, -4, -4, -4, -2, -4, -2, -4),    d: 4'd6, m: 16'hFFFE, seg: 8'hFD};
        vecs[7] = '{s: pk(1, 2, 3, 4, 5, 6, 7, 8, 100, 99),           d: 4'd8, m: 16'd100,  seg: 8'h7F};
        vecs[8] = '{s: pk(0, 0, 0, 0, 0, 0, 0, 9, 0, 0),              d: 4'd7, m: 16'd9,    seg: 8'h07};
        vecs[9] = '{s: pk(0, 0, 0, 0, 5, 0, 0, 0, 0, 0),              d: 4'd4, m: 16'd5,    seg: 8'h66};

        rst = 1'b1;
        start = 1'b0;
        load(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_max", 32'(max_score), 0);
        chk("rst_seg", 32'(seven_seg), 0);
        rst = 1'b0;

        // Idle after reset without start: nothing moves.
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("idle_activity", 32'(ndone), 0);
        chk("idle_valid", 32'(valid), 0);
        chk("idle_seg", 32'(seven_seg), 0);

        // Reset mid-scan: start sampled at edge T, rst sampled at edge T+5.
        load(vecs[0].s);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_busy_scan", 32'(busy), 1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_seg", 32'(seven_seg), 0);
        chk("abort_digit", 32'(digit), 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 0);
        chk("abort_still_invalid", 32'(valid), 0);

        // Table-driven classifications.
        for (int v = 0; v < 10; v++) begin
            load(vecs[v].s);
            run_and_wait($sformatf("vec%0d", v), lat);
            chk($sformatf("vec%0d_digit", v), 32'(digit), 32'(vecs[v].d));
            chk($sformatf("vec%0d_max", v), 32'(max_score), 32'(vecs[v].m));
            chk($sformatf("vec%0d_seg", v), 32'(seven_seg), 32'(vecs[v].seg));
            chk($sformatf("vec%0d_valid", v), 32'(valid), 1);
            chk($sformatf("vec%0d_busy_at_done", v), 32'(busy), 0);
            load(pk(-1, -1, -1, -1, -1, -1, -1, -1, -1, -1));
            tick();
            chk($sformatf("vec%0d_done_pulse", v), 32'(done), 0);
            chk($sformatf("vec%0d_hold_digit", v), 32'(digit), 32'(vecs[v].d));
            chk($sformatf("vec%0d_hold_seg", v), 32'(seven_seg), 32'(vecs[v].seg));
        end

        // Scores change after the start edge and a second start arrives at T+3.
        load(vecs[0].s);
        start = 1'b1;
        tick();
        start = 1'b0;
        load(vecs[8].s);
        ndone = 0;
        lat = 0;
        for (int c = 1; c <= 16; c++) begin
            start = (c == 3);
            tick();
            if (done === 1'b1) begin
                ndone++;
                lat = c;
                hold_d = digit;
                chk("snap_max", 32'(max_score), 32'd40);
                chk("snap_seg", 32'(seven_seg), 32'h4F);
            end
        end
        start = 1'b0;
        chk("snap_done_count", 32'(ndone), 1);
        chk("snap_latency", 32'(lat), 32'd10);
        chk("snap_digit", 32'(digit), 32'd3);

        // Start presented while in COMMIT is dropped.
        load(vecs[5].s);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        chk("commit_busy", 32'(busy), 1);
        load(vecs[9].s);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("commit_done", 32'(done), 1);
        chk("commit_digit", 32'(digit), 32'd5);
        tick();
        chk("commit_start_ignored", 32'(busy), 0);

        // Fresh run after everything above still completes in ten cycles.
        load(vecs[1].s);
        run_and_wait("final", lat);
        chk("final_seg", 32'(seven_seg), 32'h5B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
